// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel write engine: default frame geometry,
// K-bus field layout, command payload type and FSM state encoding.
package pixel_pkg;

    // Default frame and buffering geometry.
    localparam int unsigned FB_WIDTH_DEF   = 160;
    localparam int unsigned FB_HEIGHT_DEF  = 120;
    localparam int unsigned FIFO_DEPTH_DEF = 8;
    localparam int unsigned ADDR_W_DEF     = 15;

    // K-bus command layout: {X[23:16], Y[15:8], Colour[7:0]}.
    localparam int unsigned KBUS_W  = 24;
    localparam int unsigned FIELD_W = 8;
    localparam int unsigned X_MSB   = 23;
    localparam int unsigned Y_MSB   = 15;
    localparam int unsigned C_MSB   = 7;

    // Write-engine FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    // Decoded pixel command.
    typedef struct packed {
        logic [FIELD_W-1:0] x;
        logic [FIELD_W-1:0] y;
        logic [FIELD_W-1:0] c;
    } kbus_cmd_t;

    // Split a raw K-bus word into its fields.
    function automatic kbus_cmd_t unpack_cmd(input logic [KBUS_W-1:0] d);
        kbus_cmd_t cmd;
        cmd.x = d[X_MSB -: FIELD_W];
        cmd.y = d[Y_MSB -: FIELD_W];
        cmd.c = d[C_MSB -: FIELD_W];
        return cmd;
    endfunction

endpackage

// File: rtl/pix_fifo.sv
// Synchronous command FIFO.
// Ports:
//   clk, rst_n      clock / async active-low reset
//   push, din       write request and data (ignored when full)
//   pop             read request (ignored when empty); dout is the current head
//   full, empty     registered status flags
//   full_nxt_c      combinational full flag as it will be after this edge
//   empty_nxt_c     combinational empty flag as it will be after this edge
module pix_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             full_nxt_c,
    output logic             empty_nxt_c
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic             full_q, empty_q;
    logic             push_ok, pop_ok;

    assign push_ok = push && !full_q;
    assign pop_ok  = pop  && !empty_q;

    // Next pointers; the extra MSB distinguishes full from empty on wrap.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) wptr_d = wptr_q + PTR_W'(1);
        if (pop_ok)  rptr_d = rptr_q + PTR_W'(1);
    end

    assign full_nxt_c  = (wptr_d[IDX_W] != rptr_d[IDX_W]) &&
                         (wptr_d[IDX_W-1:0] == rptr_d[IDX_W-1:0]);
    assign empty_nxt_c = (wptr_d == rptr_d);

    // Pointer and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            full_q  <= full_nxt_c;
            empty_q <= empty_nxt_c;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q[IDX_W-1:0]] <= din;
    end

    assign dout  = mem_q[rptr_q[IDX_W-1:0]];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/pixel_write_engine.sv
// Pixel write engine: accepts K-bus pixel commands, queues them, clips
// against the frame, linearises the address and writes surviving pixels to
// the framebuffer over a req/ack handshake.
// Ports:
//   clk, rst_n              clock / async active-low reset
//   kbus_valid, kbus_data   incoming command {X, Y, Colour}
//   kbus_ready              command accepted when valid && ready
//   fb_req, fb_addr,        framebuffer write request, held until fb_ack
//   fb_wdata, fb_ack
//   clip_count              saturating count of clipped commands
//   write_count             wrapping count of pixels written
//   busy                    FIFO non-empty or FSM not idle
module pixel_write_engine
    import pixel_pkg::*;
#(
    parameter int unsigned FB_WIDTH   = FB_WIDTH_DEF,
    parameter int unsigned FB_HEIGHT  = FB_HEIGHT_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              kbus_valid,
    input  logic [23:0]       kbus_data,
    output logic              kbus_ready,
    output logic              fb_req,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [7:0]        fb_wdata,
    input  logic              fb_ack,
    output logic [7:0]        clip_count,
    output logic [15:0]       write_count,
    output logic              busy
);

    localparam int unsigned CNT_CLIP_W  = 8;
    localparam int unsigned CNT_WRITE_W = 16;

    // FIFO interface.
    logic              fifo_push, fifo_pop;
    logic [KBUS_W-1:0] fifo_dout;
    logic              fifo_full, fifo_empty;
    logic              fifo_full_nxt, fifo_empty_nxt;
    kbus_cmd_t         head;

    // State and datapath registers.
    state_e                 state_q, state_d;
    logic [FIELD_W-1:0]     x_q, x_d;
    logic [FIELD_W-1:0]     y_q, y_d;
    logic [FIELD_W-1:0]     c_q, c_d;
    logic                   fb_req_q, fb_req_d;
    logic [ADDR_W-1:0]      fb_addr_q, fb_addr_d;
    logic [7:0]             fb_wdata_q, fb_wdata_d;
    logic [CNT_CLIP_W-1:0]  clip_q, clip_d;
    logic [CNT_WRITE_W-1:0] wcnt_q, wcnt_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   clipped;

    // A push is blocked whenever the FIFO is full, regardless of a same-cycle pop.
    assign fifo_push = kbus_valid && !fifo_full;

    pix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (KBUS_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (fifo_push),
        .din         (kbus_data),
        .pop         (fifo_pop),
        .dout        (fifo_dout),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .full_nxt_c  (fifo_full_nxt),
        .empty_nxt_c (fifo_empty_nxt)
    );

    assign head = unpack_cmd(fifo_dout);

    // Out-of-frame test on the held command.
    assign clipped = (32'(x_q) >= FB_WIDTH) || (32'(y_q) >= FB_HEIGHT);

    // Next-state, datapath and counter logic.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        c_d        = c_q;
        fb_req_d   = fb_req_q;
        fb_addr_d  = fb_addr_q;
        fb_wdata_d = fb_wdata_q;
        clip_d     = clip_q;
        wcnt_d     = wcnt_q;
        fifo_pop   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    x_d      = head.x;
                    y_d      = head.y;
                    c_d      = head.c;
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (clipped) begin
                    if (clip_q != {CNT_CLIP_W{1'b1}}) begin
                        clip_d = clip_q + CNT_CLIP_W'(1);
                    end
                    state_d = ST_IDLE;
                end else begin
                    // In-range coordinates always fit in ADDR_W bits.
                    fb_addr_d  = ADDR_W'(y_q) * ADDR_W'(FB_WIDTH) + ADDR_W'(x_q);
                    fb_wdata_d = c_q;
                    fb_req_d   = 1'b1;
                    state_d    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (fb_ack) begin
                    fb_req_d = 1'b0;
                    wcnt_d   = wcnt_q + CNT_WRITE_W'(1);
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                fb_req_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase

        ready_d = !fifo_full_nxt;
        busy_d  = !fifo_empty_nxt || (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            c_q        <= '0;
            fb_req_q   <= 1'b0;
            fb_addr_q  <= '0;
            fb_wdata_q <= '0;
            clip_q     <= '0;
            wcnt_q     <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            c_q        <= c_d;
            fb_req_q   <= fb_req_d;
            fb_addr_q  <= fb_addr_d;
            fb_wdata_q <= fb_wdata_d;
            clip_q     <= clip_d;
            wcnt_q     <= wcnt_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    assign kbus_ready  = ready_q;
    assign fb_req      = fb_req_q;
    assign fb_addr     = fb_addr_q;
    assign fb_wdata    = fb_wdata_q;
    assign clip_count  = clip_q;
    assign write_count = wcnt_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_pixel_write_engine.sv
// Self-checking bench for pixel_write_engine.
module tb_pixel_write_engine;

    localparam int FBW = 160;
    localparam int FBH = 120;

    logic        clk;
    logic        rst_n;
    logic        kbus_valid;
    logic [23:0] kbus_data;
    logic        kbus_ready;
    logic        fb_req;
    logic [14:0] fb_addr;
    logic [7:0]  fb_wdata;
    logic        fb_ack;
    logic [7:0]  clip_count;
    logic [15:0] write_count;
    logic        busy;

    pixel_write_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .kbus_valid  (kbus_valid),
        .kbus_data   (kbus_data),
        .kbus_ready  (kbus_ready),
        .fb_req      (fb_req),
        .fb_addr     (fb_addr),
        .fb_wdata    (fb_wdata),
        .fb_ack      (fb_ack),
        .clip_count  (clip_count),
        .write_count (write_count),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int x;
        int y;
        int c;
        bit clip;
        int addr;
    } vec_t;

    int  n_checks = 0;
    int  n_fail   = 0;
    wr_t exp_q[$];
    int  wr_log[$];
    int  m_clip   = 0;
    int  m_writes = 0;
    bit  prev_wfire = 0;
    bit  last_fire  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [23:0] mk(input int x, input int y, input int c);
        logic [7:0] xb, yb, cb;
        xb = 8'(x);
        yb = 8'(y);
        cb = 8'(c);
        return {xb, yb, cb};
    endfunction

    // Reference model: clip decision and linear address from the frame rules.
    task automatic model_accept(input logic [23:0] d);
        int  x, y, c;
        wr_t w;
        x = int'(d[23:16]);
        y = int'(d[15:8]);
        c = int'(d[7:0]);
        if (x >= FBW || y >= FBH) begin
            m_clip++;
        end else begin
            w.addr = y * FBW + x;
            w.data = c;
            exp_q.push_back(w);
        end
    endtask

    function automatic int sat_clip();
        return (m_clip > 255) ? 255 : m_clip;
    endfunction

    // One clock: inputs are stable here, so handshakes seen now occur at the next edge.
    task automatic cycle();
        bit  fire, wfire;
        wr_t w;
        fire  = kbus_valid && kbus_ready;
        wfire = fb_req && fb_ack;
        if (prev_wfire) check("req_one_cycle", fb_req, 0);
        if (fire) model_accept(kbus_data);
        if (wfire) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                w = exp_q.pop_front();
                check("wr_addr", fb_addr, w.addr);
                check("wr_data", fb_wdata, w.data);
            end
            wr_log.push_back(int'(fb_addr));
            m_writes++;
        end
        prev_wfire = wfire;
        last_fire  = fire;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            cycle();
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
        cycle();
    endtask

    task automatic push_one(input logic [23:0] d);
        int n;
        n = 0;
        kbus_valid = 1'b1;
        kbus_data  = d;
        last_fire  = 0;
        while (!last_fire && n < 200) begin
            cycle();
            n++;
        end
        if (!last_fire) check("push_timeout", 1, 0);
        kbus_valid = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        int w0, c0, acc, n;

        vecs[0] = '{x: 3,   y: 2,   c: 'hAA, clip: 0, addr: 323};
        vecs[1] = '{x: 159, y: 119, c: 'h5F, clip: 0, addr: 19199};
        vecs[2] = '{x: 160, y: 0,   c: 'h12, clip: 1, addr: 0};
        vecs[3] = '{x: 0,   y: 120, c: 'h34, clip: 1, addr: 0};
        vecs[4] = '{x: 0,   y: 0,   c: 'h01, clip: 0, addr: 0};
        vecs[5] = '{x: 255, y: 255, c: 'h77, clip: 1, addr: 0};
        vecs[6] = '{x: 159, y: 0,   c: 'h9C, clip: 0, addr: 159};
        vecs[7] = '{x: 0,   y: 119, c: 'hE1, clip: 0, addr: 19040};

        rst_n      = 1'b0;
        kbus_valid = 1'b0;
        kbus_data  = '0;
        fb_ack     = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values.
        check("rst_fb_req", fb_req, 0);
        check("rst_fb_addr", fb_addr, 0);
        check("rst_fb_wdata", fb_wdata, 0);
        check("rst_clip", clip_count, 0);
        check("rst_wcount", write_count, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        cycle();
        check("ready_after_rst", kbus_ready, 1);

        // Single pixel latency with ack tied high.
        kbus_valid = 1'b1;
        kbus_data  = mk(3, 2, 'hAA);
        cycle();
        kbus_valid = 1'b0;
        check("lat_k", fb_req, 0);
        cycle();
        check("lat_k1", fb_req, 0);
        cycle();
        check("lat_k2_req", fb_req, 1);
        check("lat_k2_addr", fb_addr, 323);
        check("lat_k2_data", fb_wdata, 'hAA);
        cycle();
        check("lat_k3_req", fb_req, 0);
        wait_idle(50);
        check("lat_wcount", write_count, 1);
        check("lat_busy", busy, 0);

        // Table of single commands: clip decision and address.
        foreach (vecs[i]) begin
            w0 = m_writes;
            c0 = m_clip;
            push_one(mk(vecs[i].x, vecs[i].y, vecs[i].c));
            wait_idle(50);
            check("vec_writes", m_writes - w0, vecs[i].clip ? 0 : 1);
            check("vec_clip", clip_count, c0 + (vecs[i].clip ? 1 : 0));
            check("vec_wcount", write_count, m_writes);
            if (!vecs[i].clip) check("vec_addr", wr_log[$], vecs[i].addr);
        end

        // Back-pressure: ack low, valid high.
        fb_ack     = 1'b0;
        acc        = 0;
        kbus_valid = 1'b1;
        kbus_data  = mk(10, 20, 'h40);
        for (int t = 0; t < 30; t++) begin
            cycle();
            if (last_fire) begin
                acc++;
                kbus_data = mk(10 + acc, 20 + acc, 'h40 + acc);
            end
        end
        check("bp_accepted", acc, 9);
        check("bp_ready_low", kbus_ready, 0);
        for (int t = 0; t < 20; t++) begin
            check("bp_hold_req", fb_req, 1);
            check("bp_hold_addr", fb_addr, 20 * FBW + 10);
            check("bp_hold_data", fb_wdata, 'h40);
            cycle();
        end
        kbus_valid = 1'b0;
        w0 = wr_log.size();
        fb_ack = 1'b1;
        wait_idle(200);
        check("bp_writes", wr_log.size() - w0, 9);
        for (int i = 0; i < 9 && w0 + i < wr_log.size(); i++)
            check("bp_order", wr_log[w0 + i], (20 + i) * FBW + 10 + i);

        // Interleaved clipping keeps order.
        w0 = wr_log.size();
        c0 = clip_count;
        push_one(mk(1, 1, 'h11));
        push_one(mk(200, 5, 'h22));
        push_one(mk(2, 1, 'h33));
        wait_idle(100);
        check("il_clip", clip_count, c0 + 1);
        check("il_writes", wr_log.size() - w0, 2);
        if (wr_log.size() >= w0 + 2) begin
            check("il_addr0", wr_log[w0], 161);
            check("il_addr1", wr_log[w0 + 1], 162);
        end

        // Random traffic against the model.
        for (int t = 0; t < 500; t++) begin
            kbus_valid = ($urandom_range(0, 3) != 0);
            kbus_data  = mk($urandom_range(0, 175), $urandom_range(0, 135), $urandom_range(0, 255));
            fb_ack     = 1'($urandom_range(0, 1));
            cycle();
        end
        kbus_valid = 1'b0;
        fb_ack     = 1'b1;
        wait_idle(300);
        check("rnd_clip", clip_count, sat_clip());
        check("rnd_wcount", write_count, m_writes % 65536);
        check("rnd_drained", exp_q.size(), 0);

        // Reset during WRITE with four commands queued.
        fb_ack = 1'b0;
        acc    = 0;
        n      = 0;
        kbus_valid = 1'b1;
        kbus_data  = mk(5, 1, 'h50);
        while (acc < 5 && n < 100) begin
            cycle();
            n++;
            if (last_fire) begin
                acc++;
                kbus_data = mk(5 + acc, 1, 'h50 + acc);
            end
        end
        kbus_valid = 1'b0;
        cycle();
        cycle();
        check("mid_req_high", fb_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_req_drop", fb_req, 0);
        check("mid_addr", fb_addr, 0);
        check("mid_data", fb_wdata, 0);
        check("mid_clip", clip_count, 0);
        check("mid_wcount", write_count, 0);
        check("mid_busy", busy, 0);
        exp_q.delete();
        m_clip     = 0;
        m_writes   = 0;
        prev_wfire = 0;
        @(negedge clk);
        rst_n  = 1'b1;
        fb_ack = 1'b1;
        cycle();
        check("mid_ready", kbus_ready, 1);
        w0 = wr_log.size();
        push_one(mk(0, 0, 'h01));
        wait_idle(100);
        check("mid_fresh_writes", wr_log.size() - w0, 1);
        if (wr_log.size() > w0) check("mid_fresh_addr", wr_log[w0], 0);
        check("mid_fresh_wcount", write_count, 1);

        // Clip counter saturation.
        acc = 0;
        n   = 0;
        kbus_valid = 1'b1;
        kbus_data  = mk(200, 3, 'hCC);
        while (acc < 260 && n < 3000) begin
            cycle();
            n++;
            if (last_fire) acc++;
        end
        kbus_valid = 1'b0;
        check("sat_accepted", acc, 260);
        wait_idle(200);
        check("sat_clip", clip_count, 255);
        check("sat_wcount", write_count, 1);
        check("final_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_write_engine.md
Name: pixel_write_engine

Overview:
- Downstream consumer of the DPU K-bus: takes 24-bit pixel commands {X[23:16], Y[15:8], Colour[7:0]} from the DPU.
- Buffers commands in a small FIFO, clips them against the frame size, linearises the address, and writes each surviving pixel to framebuffer memory over a req/ack handshake.
- Decouples DPU instruction timing from memory latency.

Parameters:
- FB_WIDTH, 160, visible pixels per line.
- FB_HEIGHT, 120, visible lines.
- FIFO_DEPTH, 8, command FIFO entries; power of two, at least 2.
- ADDR_W, 15, framebuffer address width; must satisfy FB_WIDTH*FB_HEIGHT <= 2^ADDR_W.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- kbus_valid  in  1  DPU presents a pixel command.
- kbus_data  in  24  {X, Y, Colour}.
- kbus_ready  out  1  command accepted on an edge where valid&&ready.
- fb_req  out  1  framebuffer write request.
- fb_addr  out  ADDR_W  linear pixel address.
- fb_wdata  out  8  pixel colour.
- fb_ack  in  1  memory has taken the write.
- clip_count  out  8  commands discarded by clipping; saturates at 255.
- write_count  out  16  pixels written; wraps modulo 2^16.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - FIFO empties; FSM goes to IDLE.
  - fb_req=0, fb_addr=0, fb_wdata=0, clip_count=0, write_count=0, busy=0.
  - kbus_ready=1 from the first edge after rst_n rises.
- kbus_ready = !fifo_full. No push when full, even if a pop happens the same cycle.
- FSM states: IDLE, CHECK, WRITE.
- IDLE:
  - If the FIFO is non-empty, pop the head into holding registers x_r, y_r, c_r and go to CHECK.
  - Otherwise stay in IDLE.
- CHECK:
  - If x_r >= FB_WIDTH or y_r >= FB_HEIGHT: increment clip_count (saturating), leave fb_req low, go to IDLE.
  - Otherwise register fb_addr = y_r*FB_WIDTH + x_r (computed at full width, no truncation within valid range), fb_wdata = c_r, fb_req = 1, and go to WRITE.
- WRITE:
  - fb_req, fb_addr and fb_wdata are held stable while fb_ack is low.
  - On the edge where fb_ack=1: fb_req <= 0, write_count++, go to IDLE.
- fb_ack while fb_req=0 is ignored.
- Latency:
  - Command accepted at edge k; popped at k+1; fb_req high after k+2.
  - With fb_ack tied high, sustained throughput is one pixel per 3 cycles.
  - fb_req pulses exactly 1 cycle per pixel.
- Ordering: writes issue strictly in acceptance order; clipped commands are skipped without disturbing order.
- Occupancy with fb_ack held low and valid held high: exactly FIFO_DEPTH+1 commands accepted (one held, FIFO_DEPTH queued), then kbus_ready=0.
- Simultaneous push and pop on a non-full FIFO: both occur; occupancy is unchanged.
- Wrap-around: FIFO pointers use log2(FIFO_DEPTH)+1 bits; full/empty are decided by the MSB compare.
- Reset mid-WRITE: fb_req drops asynchronously; the in-flight pixel and all queued commands are discarded; no write_count increment.

Decomposition:
- Package pixel_pkg:
  - FB_WIDTH/FB_HEIGHT defaults.
  - K-bus field bit positions (X_MSB=23, Y_MSB=15, C_MSB=7).
  - FSM state encoding (IDLE=2'd0, CHECK=2'd1, WRITE=2'd2).
- One sub-module: pix_fifo, a synchronous FIFO (push, pop, din, dout, full, empty; same clk/rst_n).
- FSM, address arithmetic and counters live in the top.

Test Plan:
- Single pixel, fb_ack tied high: push {X=3, Y=2, C=0xAA} -> after edge k+2, fb_req=1, fb_addr=323, fb_wdata=0xAA for one cycle; write_count=1; busy returns to 0.
- Boundary and clip:
  - Push X=159,Y=119,C=0x5F -> fb_addr=19199.
  - Push X=160,Y=0 and X=0,Y=120 -> no fb_req; clip_count=2; write_count=1.
- Back-pressure, fb_ack held low with valid held high:
  - Exactly 9 commands accepted, then kbus_ready=0.
  - fb_req/fb_addr stay stable for 20 cycles.
  - Release fb_ack -> 9 writes in acceptance order with correct addresses.
- Interleaved clipping and order: stream (1,1,0x11),(200,5,0x22),(2,1,0x33) -> writes at addr 161 then 162 with data 0x11, 0x33; clip_count=1.
- Reset mid-operation: assert rst_n=0 during WRITE with 4 queued -> fb_req falls immediately; all counters and outputs read 0. After release, a fresh push of (0,0,0x01) writes addr 0 only.
- Saturation: 260 clipped commands -> clip_count=255.
